// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive, 2-flop column sync, press/release debounce, hex key codes.
// Optional build macro KEYPAD_GHOST_REJECT_EN rejects presses that show more than one low column.
module keypad_scanner #(
    parameter int SCAN_DIV        = 24000,
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] SCAN_ONE  = SW'(1);
    localparam logic [SW-1:0] SCAN_ZERO = SW'(0);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [DW-1:0] DEB_ZERO  = DW'(0);
`ifdef KEYPAD_GHOST_REJECT_EN
    localparam logic GHOST_REJECT = 1'b1;
`else
    localparam logic GHOST_REJECT = 1'b0;
`endif

    typedef enum logic [1:0] {ST_SCAN = 2'd0, ST_DEBOUNCE = 2'd1, ST_HELD = 2'd2} state_t;

    state_t        r_state, w_state;
    logic [3:0]    r_sync1, r_sync2;
    logic [1:0]    r_row, w_row;
    logic [1:0]    r_col, w_col;
    logic [SW-1:0] r_dwell, w_dwell;
    logic [DW-1:0] r_deb, w_deb;
    logic [3:0]    r_row_n, w_row_n;
    logic [3:0]    r_key_code, w_key_code;
    logic          r_key_valid, w_key_valid;
    logic          r_key_held, w_key_held;
    logic [3:0]    w_low;
    logic          w_multi, w_ghost, w_col_low;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] lowest_col(input logic [3:0] low);
        logic [1:0] idx;
        if (low[0]) begin
            idx = 2'd0;
        end else if (low[1]) begin
            idx = 2'd1;
        end else if (low[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    assign w_low     = ~r_sync2;
    assign w_multi   = ((w_low & (w_low - 4'd1)) != 4'd0);
    assign w_ghost   = GHOST_REJECT & w_multi;
    assign w_col_low = w_low[r_col];

    // Next-state, counters and output decisions
    always_comb begin
        w_state     = r_state;
        w_row       = r_row;
        w_col       = r_col;
        w_dwell     = r_dwell;
        w_deb       = r_deb;
        w_key_code  = r_key_code;
        w_key_valid = 1'b0;
        w_key_held  = r_key_held;
        case (r_state)
            ST_SCAN: begin
                if (r_dwell == SCAN_LAST) begin
                    w_dwell = SCAN_ZERO;
                    if ((w_low == 4'd0) || w_ghost) begin
                        w_row = r_row + 2'd1;
                    end else begin
                        w_col   = lowest_col(w_low);
                        w_deb   = DEB_ZERO;
                        w_state = ST_DEBOUNCE;
                    end
                end else begin
                    w_dwell = r_dwell + SCAN_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (!w_col_low || w_ghost) begin
                    w_deb   = DEB_ZERO;
                    w_dwell = SCAN_ZERO;
                    w_row   = r_row + 2'd1;
                    w_state = ST_SCAN;
                end else if (r_deb == DEB_LAST) begin
                    w_deb       = DEB_ZERO;
                    w_key_code  = key_map(r_row, r_col);
                    w_key_valid = 1'b1;
                    w_key_held  = 1'b1;
                    w_state     = ST_HELD;
                end else begin
                    w_deb = r_deb + DEB_ONE;
                end
            end
            ST_HELD: begin
                // Only the latched column matters; the counter here measures release time
                if (w_col_low) begin
                    w_deb = DEB_ZERO;
                end else if (r_deb == DEB_LAST) begin
                    w_deb      = DEB_ZERO;
                    w_key_held = 1'b0;
                    w_dwell    = SCAN_ZERO;
                    w_row      = r_row + 2'd1;
                    w_state    = ST_SCAN;
                end else begin
                    w_deb = r_deb + DEB_ONE;
                end
            end
            default: begin
                w_state    = ST_SCAN;
                w_row      = 2'd0;
                w_dwell    = SCAN_ZERO;
                w_deb      = DEB_ZERO;
                w_key_held = 1'b0;
            end
        endcase
        case (w_row)
            2'd0:    w_row_n = 4'b1110;
            2'd1:    w_row_n = 4'b1101;
            2'd2:    w_row_n = 4'b1011;
            2'd3:    w_row_n = 4'b0111;
            default: w_row_n = 4'b1110;
        endcase
    end

    // State register, column synchronizer and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= 4'b1111;
            r_sync2     <= 4'b1111;
            r_state     <= ST_SCAN;
            r_row       <= 2'd0;
            r_col       <= 2'd0;
            r_dwell     <= SCAN_ZERO;
            r_deb       <= DEB_ZERO;
            r_row_n     <= 4'b1110;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_sync1     <= col_n;
            r_sync2     <= r_sync1;
            r_state     <= w_state;
            r_row       <= w_row;
            r_col       <= w_col;
            r_dwell     <= w_dwell;
            r_deb       <= w_deb;
            r_row_n     <= w_row_n;
            r_key_code  <= w_key_code;
            r_key_valid <= w_key_valid;
            r_key_held  <= w_key_held;
        end
    end

    assign row_n     = r_row_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: keypad matrix model, directed key table,
// multi-cycle corner sequences and a randomized press/release scoreboard.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed = 16'h0000;
    logic [3:0]  obs_codes[$];
    logic [3:0]  exp_codes[$];
    logic        prev_valid = 1'b0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [1:0] row;
        logic [1:0] col;
        logic [3:0] code;
    } vec_t;
    vec_t vecs[16];

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .col_n(col_n), .row_n(row_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its column low while its row is driven low
    always_comb begin
        col_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: row drive shape every cycle, pulse width and captured key codes
    always @(negedge clk) begin
        check("row_one_low", 32'($countones(~row_n)), 32'd1);
        if (key_valid) begin
            obs_codes.push_back(key_code);
            check("valid_single_cycle", 32'(prev_valid), 32'd0);
        end
        prev_valid = key_valid;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic set_key(input int r, input int c, input logic v);
        pressed[r*4+c] = v;
    endtask

    task automatic wait_pulse(input int max, output bit got);
        int start;
        start = obs_codes.size();
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (obs_codes.size() > start) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_row(input logic [3:0] want, input int max, output bit got);
        got = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (row_n == want) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        run(n);
        reset = 1'b0;
    endtask

    // Reference key map derived from the printed keypad layout
    function automatic logic [3:0] ref_code(input int idx);
        string layout;
        byte   ch;
        layout = "123A456B789CE0FD";
        ch = layout[idx];
        if (ch >= 8'd48 && ch <= 8'd57) return 4'(ch - 8'd48);
        else return 4'(ch - 8'd55);
    endfunction

    initial begin
        bit         got;
        int         base;
        int         idx;
        int         hold;
        int         gap;
        logic [3:0] rows_exp[5];

        vecs[0]  = '{2'd0, 2'd0, 4'h1}; vecs[1]  = '{2'd0, 2'd1, 4'h2};
        vecs[2]  = '{2'd0, 2'd2, 4'h3}; vecs[3]  = '{2'd0, 2'd3, 4'hA};
        vecs[4]  = '{2'd1, 2'd0, 4'h4}; vecs[5]  = '{2'd1, 2'd1, 4'h5};
        vecs[6]  = '{2'd1, 2'd2, 4'h6}; vecs[7]  = '{2'd1, 2'd3, 4'hB};
        vecs[8]  = '{2'd2, 2'd0, 4'h7}; vecs[9]  = '{2'd2, 2'd1, 4'h8};
        vecs[10] = '{2'd2, 2'd2, 4'h9}; vecs[11] = '{2'd2, 2'd3, 4'hC};
        vecs[12] = '{2'd3, 2'd0, 4'hE}; vecs[13] = '{2'd3, 2'd1, 4'h0};
        vecs[14] = '{2'd3, 2'd2, 4'hF}; vecs[15] = '{2'd3, 2'd3, 4'hD};
        rows_exp[0] = 4'b1110; rows_exp[1] = 4'b1101; rows_exp[2] = 4'b1011;
        rows_exp[3] = 4'b0111; rows_exp[4] = 4'b1110;

        // 1: reset values and idle row rotation
        reset = 1'b1;
        run(3);
        check("rst_row_n", 32'(row_n), 32'hE);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_held", 32'(key_held), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("idle_row_rotation", 32'(row_n), 32'(rows_exp[i]));
            run(SD);
        end

        // 2: press '5', hold, release
        base = obs_codes.size();
        set_key(1, 1, 1'b1);
        run(40);
        check("k5_pulse_count", 32'(obs_codes.size() - base), 32'd1);
        check("k5_code", 32'(key_code), 32'h5);
        check("k5_held", 32'(key_held), 32'd1);
        set_key(1, 1, 1'b0);
        run(12);
        check("k5_released", 32'(key_held), 32'd0);
        check("k5_scan_resumes", 32'(row_n), 32'hB);

        // Directed table: every key position
        for (int i = 0; i < 16; i++) begin
            set_key(vecs[i].row, vecs[i].col, 1'b1);
            wait_pulse(60, got);
            check("tbl_pulse", 32'(got), 32'd1);
            check("tbl_code", 32'(key_code), 32'(vecs[i].code));
            check("tbl_held", 32'(key_held), 32'd1);
            set_key(vecs[i].row, vecs[i].col, 1'b0);
            run(14);
            check("tbl_release", 32'(key_held), 32'd0);
        end

        // 3: 'D' with bounce pulses shorter than the debounce window
        base = obs_codes.size();
        for (int i = 0; i < 6; i++) begin
            set_key(3, 3, 1'b1);
            run(3);
            set_key(3, 3, 1'b0);
            run(3);
        end
        check("bounce_no_valid", 32'(obs_codes.size() - base), 32'd0);
        set_key(3, 3, 1'b1);
        wait_pulse(40, got);
        check("bounce_then_pulse", 32'(got), 32'd1);
        check("bounce_code", 32'(key_code), 32'hD);
        run(20);
        check("bounce_one_pulse", 32'(obs_codes.size() - base), 32'd1);
        set_key(3, 3, 1'b0);
        run(20);

        // 6: reset in the middle of debouncing '7'
        wait_row(4'b1101, 20, got);
        check("mid_reset_row1_seen", 32'(got), 32'd1);
        base = obs_codes.size();
        set_key(2, 0, 1'b1);
        wait_row(4'b1011, 20, got);
        check("mid_reset_row2_seen", 32'(got), 32'd1);
        run(7);
        reset = 1'b1;
        tick();
        check("mid_reset_row_n", 32'(row_n), 32'hE);
        check("mid_reset_code", 32'(key_code), 32'h0);
        check("mid_reset_valid", 32'(key_valid), 32'd0);
        check("mid_reset_held", 32'(key_held), 32'd0);
        run(5);
        set_key(2, 0, 1'b0);
        reset = 1'b0;
        run(20);
        check("mid_reset_no_pulse", 32'(obs_codes.size() - base), 32'd0);

        // 4: '1' and '3' together in row 0
        base = obs_codes.size();
        set_key(0, 0, 1'b1);
        set_key(0, 2, 1'b1);
        run(40);
`ifdef KEYPAD_GHOST_REJECT_EN
        check("ghost_no_pulse", 32'(obs_codes.size() - base), 32'd0);
        check("ghost_code_kept", 32'(key_code), 32'h0);
`else
        check("multi_one_pulse", 32'(obs_codes.size() - base), 32'd1);
        check("multi_lowest_col", 32'(key_code), 32'h1);
`endif
        set_key(0, 0, 1'b0);
        set_key(0, 2, 1'b0);
        run(20);

        // 5: '2' pressed while '9' is held
        set_key(2, 2, 1'b1);
        wait_pulse(40, got);
        check("k9_pulse", 32'(got), 32'd1);
        check("k9_code", 32'(key_code), 32'h9);
        base = obs_codes.size();
        set_key(0, 1, 1'b1);
        run(30);
        check("held_ignores_other", 32'(obs_codes.size() - base), 32'd0);
        check("held_code_kept", 32'(key_code), 32'h9);
        set_key(2, 2, 1'b0);
        wait_pulse(60, got);
        check("k2_after_release", 32'(got), 32'd1);
        check("k2_code", 32'(key_code), 32'h2);
        set_key(0, 1, 1'b0);
        run(20);

        // Randomized single-key presses against the layout scoreboard
        do_reset(2);
        base = obs_codes.size();
        for (int i = 0; i < 30; i++) begin
            idx  = int'($urandom_range(15, 0));
            hold = int'($urandom_range(60, 40));
            gap  = int'($urandom_range(30, 14));
            pressed[idx] = 1'b1;
            run(hold);
            check("rand_held", 32'(key_held), 32'd1);
            pressed[idx] = 1'b0;
            run(gap);
            check("rand_released", 32'(key_held), 32'd0);
            exp_codes.push_back(ref_code(idx));
        end
        check("rand_pulse_count", 32'(obs_codes.size() - base), 32'(exp_codes.size()));
        for (int i = 0; i < exp_codes.size(); i++) begin
            if (base + i < obs_codes.size())
                check("rand_code", 32'(obs_codes[base+i]), 32'(exp_codes[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
